// File: rtl/superalu_share_arbiter.sv
// Two-port round-robin arbiter in front of the shared super ALU (mul/div/sqrt/cordic).
// Latches the winner's operands, drives the ALU start/done handshake and returns results with a watchdog abort.
module superalu_share_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int OP_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic [OP_WIDTH-1:0]   OP0,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic [OP_WIDTH-1:0]   OP1,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  output logic [1:0]            ACK,
  output logic [DATA_WIDTH-1:0] RES_F,
  output logic [DATA_WIDTH-1:0] RES_P,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  GNT_ID,
  output logic                  ALU_START,
  output logic [OP_WIDTH-1:0]   ALU_OP,
  output logic [DATA_WIDTH-1:0] ALU_XIN,
  output logic [DATA_WIDTH-1:0] ALU_YIN,
  input  logic [DATA_WIDTH-1:0] ALU_FOUT,
  input  logic [DATA_WIDTH-1:0] ALU_POUT,
  input  logic                  ALU_DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Counter value seen on the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic [1:0]            ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] res_f_q, res_f_d;
  logic [DATA_WIDTH-1:0] res_p_q, res_p_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  win_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
    err_d   = err_q;
    start_d = 1'b0;
    res_f_d = res_f_q;
    res_p_d = res_p_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    win_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          // On a tie, the requester that was not granted last time wins.
          win_s   = (REQ == 2'b11) ? ~gnt_q : REQ[1];
          gnt_d   = win_s;
          op_d    = win_s ? OP1 : OP0;
          x_d     = win_s ? A1 : A0;
          y_d     = win_s ? B1 : B0;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = {CNT_WIDTH{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ALU_DONE) begin
          res_f_d = ALU_FOUT;
          res_p_d = ALU_POUT;
          err_d   = 1'b0;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_f_d = {DATA_WIDTH{1'b0}};
          res_p_d = {DATA_WIDTH{1'b0}};
          err_d   = 1'b1;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_WIDTH{1'b0}};
      gnt_q   <= 1'b1;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      res_f_q <= {DATA_WIDTH{1'b0}};
      res_p_q <= {DATA_WIDTH{1'b0}};
      op_q    <= {OP_WIDTH{1'b0}};
      x_q     <= {DATA_WIDTH{1'b0}};
      y_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      res_f_q <= res_f_d;
      res_p_q <= res_p_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign ACK       = ack_q;
  assign RES_F     = res_f_q;
  assign RES_P     = res_p_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign GNT_ID    = gnt_q;
  assign ALU_START = start_q;
  assign ALU_OP    = op_q;
  assign ALU_XIN   = x_q;
  assign ALU_YIN   = y_q;

endmodule

// File: tb/tb_superalu_share_arbiter.sv
// Directed bench for superalu_share_arbiter with a delay-programmable ALU stub.
// Expected values are hand-computed constants; outputs are sampled on the falling edge.
module tb_superalu_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ;
  logic [1:0]  OP0, OP1;
  logic [15:0] A0, B0, A1, B1;
  logic [1:0]  ACK;
  logic [15:0] RES_F, RES_P;
  logic        ERR, BUSY, GNT_ID, ALU_START;
  logic [1:0]  ALU_OP;
  logic [15:0] ALU_XIN, ALU_YIN;
  logic [15:0] ALU_FOUT, ALU_POUT;
  logic        ALU_DONE;

  int n_cmp = 0;
  int n_err = 0;

  superalu_share_arbiter #(
    .DATA_WIDTH(16), .OP_WIDTH(2), .TIMEOUT_CYCLES(10), .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .OP0(OP0), .A0(A0), .B0(B0), .OP1(OP1), .A1(A1), .B1(B1),
    .ACK(ACK), .RES_F(RES_F), .RES_P(RES_P), .ERR(ERR), .BUSY(BUSY), .GNT_ID(GNT_ID),
    .ALU_START(ALU_START), .ALU_OP(ALU_OP), .ALU_XIN(ALU_XIN), .ALU_YIN(ALU_YIN),
    .ALU_FOUT(ALU_FOUT), .ALU_POUT(ALU_POUT), .ALU_DONE(ALU_DONE)
  );

  always #5 CLK = ~CLK;

  // ALU stub: DONE rises alu_dly cycles after the START cycle; alu_dly == 0 never completes.
  int alu_dly = 5;
  int alu_cnt = 0;
  always @(posedge CLK) begin
    if (ALU_START) alu_cnt <= alu_dly;
    else if (alu_cnt != 0) alu_cnt <= alu_cnt - 1;
  end
  assign ALU_DONE = (alu_cnt == 1);

  logic [31:0] prod;
  always_comb begin
    prod     = 32'd0;
    ALU_FOUT = 16'd0;
    ALU_POUT = 16'd0;
    case (ALU_OP)
      2'b00: begin
        prod     = ALU_XIN * ALU_YIN;
        ALU_FOUT = prod[15:0];
        ALU_POUT = prod[31:16];
      end
      2'b01: begin
        ALU_FOUT = (ALU_YIN != 16'd0) ? ALU_XIN / ALU_YIN : 16'hFFFF;
        ALU_POUT = (ALU_YIN != 16'd0) ? ALU_XIN % ALU_YIN : ALU_XIN;
      end
      default: begin
        ALU_FOUT = ALU_XIN;
        ALU_POUT = ALU_YIN;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  got_ack;
  logic [15:0] got_f, got_p;
  logic        got_err, got_gnt, got_busy;
  int          got_lat, got_starts;

  // Waits (bounded) for an ACK pulse; got_lat counts falling edges since the call.
  task automatic wait_ack(input int budget);
    got_ack = 2'b00; got_lat = 0; got_starts = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (ALU_START) got_starts++;
      if (ACK != 2'b00) begin
        got_ack = ACK; got_f = RES_F; got_p = RES_P; got_err = ERR;
        got_gnt = GNT_ID; got_busy = BUSY; got_lat = k;
        break;
      end
    end
    chk("ack_within_budget", {31'd0, got_ack != 2'b00}, 32'd1);
  endtask

  int ack_seen;

  initial begin
    RST = 1'b1; REQ = 2'b00;
    OP0 = 2'b00; A0 = 16'd58;  B0 = 16'd50;
    OP1 = 2'b01; A1 = 16'd369; B1 = 16'd8;
    repeat (2) @(negedge CLK);
    chk("rst_ack", ACK, 2'b00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_gnt", GNT_ID, 1'b1);
    chk("rst_start", ALU_START, 1'b0);
    chk("rst_resf", RES_F, 16'd0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_xin", ALU_XIN, 16'd0);
    RST = 1'b0;

    // Single multiply 58*50 = 2900; ACK on cycle 8 counting the REQ cycle as 1.
    REQ = 2'b01;
    wait_ack(20);
    REQ = 2'b00;
    chk("mul_ack", got_ack, 2'b01);
    chk("mul_lat", got_lat, 32'd7);
    chk("mul_f", got_f, 16'h0B54);
    chk("mul_p", got_p, 16'h0000);
    chk("mul_err", got_err, 1'b0);
    chk("mul_starts", got_starts, 32'd1);
    chk("mul_busy_resp", got_busy, 1'b1);
    @(negedge CLK);
    chk("mul_ack_one_cycle", ACK, 2'b00);
    chk("mul_busy_idle", BUSY, 1'b0);

    // Contention from reset: requester 0 first, then requester 1 (369/8 = 46 r 1).
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    REQ = 2'b11;
    wait_ack(20);
    chk("cont0_ack", got_ack, 2'b01);
    chk("cont0_gnt", got_gnt, 1'b0);
    REQ = 2'b10;
    wait_ack(20);
    REQ = 2'b00;
    chk("cont1_ack", got_ack, 2'b10);
    chk("cont1_gnt", got_gnt, 1'b1);
    chk("cont1_f", got_f, 16'd46);
    chk("cont1_p", got_p, 16'd1);
    @(negedge CLK);

    // Fairness under continuous dual load.
    REQ = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_ack(20);
      chk("fair_ack", got_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("fair_f", got_f, (i % 2 == 0) ? 16'h0B54 : 16'd46);
    end
    REQ = 2'b00;
    @(negedge CLK);

    // Timeout: ALU never completes, abort on the 10th WAIT cycle.
    alu_dly = 0;
    REQ = 2'b01;
    wait_ack(30);
    REQ = 2'b00;
    chk("to_ack", got_ack, 2'b01);
    chk("to_err", got_err, 1'b1);
    chk("to_f", got_f, 16'd0);
    chk("to_p", got_p, 16'd0);
    chk("to_lat", got_lat, 32'd12);
    @(negedge CLK);

    // Normal service after a timeout.
    alu_dly = 5;
    REQ = 2'b01;
    wait_ack(20);
    REQ = 2'b00;
    chk("post_to_err", got_err, 1'b0);
    chk("post_to_f", got_f, 16'h0B54);
    @(negedge CLK);

    // Minimum latency: DONE in the first WAIT cycle.
    alu_dly = 1;
    REQ = 2'b10;
    wait_ack(20);
    REQ = 2'b00;
    chk("min_ack", got_ack, 2'b10);
    chk("min_lat", got_lat, 32'd3);
    chk("min_f", got_f, 16'd46);
    @(negedge CLK);

    // DONE coincides with the timeout: result wins, 3*7 = 21.
    alu_dly = 10; A0 = 16'd3; B0 = 16'd7;
    REQ = 2'b01;
    wait_ack(30);
    REQ = 2'b00;
    chk("coin_err", got_err, 1'b0);
    chk("coin_f", got_f, 16'd21);
    chk("coin_lat", got_lat, 32'd12);
    @(negedge CLK);

    // DONE one cycle too late: timeout.
    alu_dly = 11;
    REQ = 2'b01;
    wait_ack(30);
    REQ = 2'b00;
    chk("late_err", got_err, 1'b1);
    chk("late_f", got_f, 16'd0);
    repeat (3) @(negedge CLK);

    // REQ dropped after grant, operands changed during WAIT.
    alu_dly = 5; A0 = 16'd58; B0 = 16'd50;
    REQ = 2'b01;
    @(negedge CLK);
    chk("drop_start", ALU_START, 1'b1);
    chk("drop_xin_issue", ALU_XIN, 16'd58);
    REQ = 2'b00;
    @(negedge CLK);
    A0 = 16'h1234; OP0 = 2'b01;
    @(negedge CLK);
    chk("drop_xin_wait", ALU_XIN, 16'd58);
    chk("drop_op_wait", ALU_OP, 2'b00);
    wait_ack(20);
    chk("drop_ack", got_ack, 2'b01);
    chk("drop_f", got_f, 16'h0B54);
    chk("drop_lat", got_lat, 32'd4);
    A0 = 16'd58; OP0 = 2'b00;
    @(negedge CLK);

    // Reset in WAIT: silent abort, the late DONE is ignored.
    REQ = 2'b01;
    repeat (3) @(negedge CLK);
    REQ = 2'b00; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_busy", BUSY, 1'b0);
    chk("mid_ack", ACK, 2'b00);
    chk("mid_resf", RES_F, 16'd0);
    chk("mid_xin", ALU_XIN, 16'd0);
    chk("mid_gnt", GNT_ID, 1'b1);
    ack_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (ACK != 2'b00) ack_seen++;
    end
    chk("mid_no_ack", ack_seen, 32'd0);
    REQ = 2'b10;
    wait_ack(20);
    REQ = 2'b00;
    chk("mid_next_ack", got_ack, 2'b10);
    chk("mid_next_f", got_f, 16'd46);
    chk("mid_next_p", got_p, 16'd1);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/superalu_share_arbiter.md
Name: superalu_share_arbiter

Overview:
- Shares the single super ALU (multiply, divide, sqrt, CORDIC) between two requesters: port 0 is the SCPU, port 1 is the serial CTRL/SPI host path.
- Arbitrates round-robin, latches the operands, sequences the ALU start/done handshake and returns FOUT/POUT to the winner.
- Includes a watchdog that recovers from an ALU that never completes.
- Sits between the SCPU/CTRL front ends and the super ALU inside the top-level SRAM/ALU/SPI wrapper.

Parameters:
- DATA_WIDTH, 16, operand and result width.
- OP_WIDTH, 2, ALU opcode width (00 mul, 01 div, 10 sqrt, 11 cordic).
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before an error abort. Minimum 1.
- CNT_WIDTH, 8, width of the watchdog counter. Must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester request; held high until the matching ACK bit.
- OP0  in  OP_WIDTH  requester 0 opcode.
- A0  in  DATA_WIDTH  requester 0 XIN.
- B0  in  DATA_WIDTH  requester 0 YIN.
- OP1  in  OP_WIDTH  requester 1 opcode.
- A1  in  DATA_WIDTH  requester 1 XIN.
- B1  in  DATA_WIDTH  requester 1 YIN.
- ACK  out  2  one-cycle completion pulse to the granted requester.
- RES_F  out  DATA_WIDTH  FOUT result; valid while ACK is high.
- RES_P  out  DATA_WIDTH  POUT result; valid while ACK is high.
- ERR  out  1  with ACK: the operation timed out.
- BUSY  out  1  high in any state other than IDLE.
- GNT_ID  out  1  index of the current or last granted requester.
- ALU_START  out  1  one-cycle start strobe to the ALU.
- ALU_OP  out  OP_WIDTH  latched opcode.
- ALU_XIN  out  DATA_WIDTH  latched operand A.
- ALU_YIN  out  DATA_WIDTH  latched operand B.
- ALU_FOUT  in  DATA_WIDTH  ALU result F.
- ALU_POUT  in  DATA_WIDTH  ALU result P.
- ALU_DONE  in  1  ALU completion; sampled only in WAIT.

Behaviour:
- Reset (RST high at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including the ACK, ERR, ALU_START, result and operand registers.
  - GNT_ID=1, so requester 0 wins the first tie.
  - Watchdog counter cleared.
  - Reset mid-operation aborts silently: no ACK is issued, and a later ALU_DONE is ignored because the block is no longer in WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If REQ!=0, arbitrate in that cycle.
    - Single requester: it wins.
    - Both requesting: the winner is the index not equal to GNT_ID (round-robin).
  - Latch the winner's OP/A/B into ALU_OP/ALU_XIN/ALU_YIN, update GNT_ID, go to ISSUE.
- ISSUE:
  - ALU_START=1 for exactly this cycle.
  - Clear the watchdog, go to WAIT.
- WAIT:
  - ALU_DONE=1: capture ALU_FOUT/ALU_POUT into RES_F/RES_P, set ERR=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT_CYCLES: RES_F=RES_P=0, ERR=1, go to RESP.
  - If ALU_DONE and the timeout coincide, ALU_DONE wins and ERR=0.
- RESP:
  - ACK[GNT_ID]=1 for one cycle; RES_F/RES_P/ERR are valid.
  - Return to IDLE.
  - Results hold their value until the next capture.
- Latency from REQ seen in IDLE to ACK: 3 + D cycles, where D ≥ 1 is the number of WAIT cycles up to and including the ALU_DONE cycle. Minimum is 4 cycles.
- Back-to-back operation:
  - After RESP, IDLE arbitrates on the following cycle.
  - A requester must drop REQ in the cycle after its ACK, otherwise it is treated as a new request.
  - Under continuous dual load, grants alternate 0,1,0,1.
- REQ dropping:
  - Dropped before the grant: no effect.
  - Dropped after the grant: the operation still completes and ACK still pulses.
- Operand or opcode changes after the grant have no effect; the values were latched in IDLE.
- ALU_OP/ALU_XIN/ALU_YIN stay stable from ISSUE through RESP.
- BUSY=1 in ISSUE, WAIT and RESP.

Test Plan:
- Single multiply: REQ=01, OP0=00, A0=58, B0=50; ALU model responds with DONE 5 cycles after START, {POUT,FOUT}=2900. Required: ACK=01 at cycle 8, RES_F=16'h0B54, RES_P=0, ERR=0, ALU_START high exactly 1 cycle.
- Contention: REQ=11 from reset. Required: requester 0 served first, then requester 1. Requester 1 has OP1=01 (divide), A1=369, B1=8; required RES_F=46, RES_P=1, ACK=10. GNT_ID sequence 0,1.
- Fairness: hold REQ=11 for 6 operations. Required: ACK alternates 01,10,01,10,01,10 and no requester is starved.
- Timeout: ALU model never asserts DONE, TIMEOUT_CYCLES=10. Required: ACK=01 with ERR=1 and RES_F=RES_P=0; the next request is served normally with ERR=0.
- Edges: ALU_DONE in the same cycle as the timeout gives ERR=0 with the captured result. A REQ drop after the grant still produces the ACK pulse. Changing A0 during WAIT leaves ALU_XIN unchanged.
- Reset mid-WAIT: assert RST for 1 cycle. Required: IDLE, all outputs 0, a subsequent ALU_DONE produces no ACK, and the next REQ=10 is granted to requester 1 normally.
